// File: rtl/rgb_mixer_pkg.sv
// rtl/rgb_mixer_pkg.sv - shared types and constants for the RGB mixer encoder front end
// Contents: channel_e (colour channel select), LEVEL_W_DEF (default level width),
//           AB_IDLE (quadrature detent rest state), next_channel (R->G->B->R).
package rgb_mixer_pkg;

    typedef enum logic [1:0] {
        CH_RED   = 2'd0,
        CH_GREEN = 2'd1,
        CH_BLUE  = 2'd2
    } channel_e;

    localparam int         LEVEL_W_DEF = 8;
    localparam logic [1:0] AB_IDLE     = 2'b11;

    // Channel code 3 is never produced; it falls back to red if ever seen.
    function automatic channel_e next_channel(input channel_e ch);
        channel_e nxt;
        case (ch)
            CH_RED:   nxt = CH_GREEN;
            CH_GREEN: nxt = CH_BLUE;
            default:  nxt = CH_RED;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchroniser followed by a stable-count debouncer
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active low
//   i_raw    in   asynchronous raw pin
//   o_level  out  debounced level (RESET_VAL out of reset)
// Parameters:
//   CYCLES    consecutive cycles the synced value must differ before it is accepted (>=1)
//   RESET_VAL value loaded into the sync flops and the debounced output on reset
module input_debouncer #(
    parameter int   CYCLES    = 1000,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int                CNT_W    = (CYCLES < 2) ? 1 : $clog2(CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;

    // The counter only advances while the synced input disagrees with the
    // accepted level; any agreement clears it, so a glitch shorter than
    // CYCLES never reaches the output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync0 <= RESET_VAL;
            r_sync1 <= RESET_VAL;
            r_deb   <= RESET_VAL;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_raw;
            r_sync1 <= r_sync0;
            if (r_sync1 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= r_sync1;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_deb;

endmodule

// File: rtl/rgb_encoder_frontend.sv
// rtl/rgb_encoder_frontend.sv - rotary encoder conditioning, detent decode and RGB level registers
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active low
//   encoder_A    in   raw quadrature phase A (idle high)
//   encoder_B    in   raw quadrature phase B (idle high)
//   encoder_btn  in   raw push button (1 = pressed)
//   red_level    out  red PWM duty cycle
//   green_level  out  green PWM duty cycle
//   blue_level   out  blue PWM duty cycle
//   sel_channel  out  active channel (0 = R, 1 = G, 2 = B)
//   step_cw      out  one-cycle pulse per clockwise detent
//   step_ccw     out  one-cycle pulse per counter-clockwise detent
import rgb_mixer_pkg::*;

module rgb_encoder_frontend #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STEP            = 1,
    parameter int LEVEL_W         = LEVEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               encoder_A,
    input  logic               encoder_B,
    input  logic               encoder_btn,
    output logic [LEVEL_W-1:0] red_level,
    output logic [LEVEL_W-1:0] green_level,
    output logic [LEVEL_W-1:0] blue_level,
    output logic [1:0]         sel_channel,
    output logic               step_cw,
    output logic               step_ccw
);

    localparam logic [LEVEL_W:0]   STEP_EXT  = (LEVEL_W + 1)'(STEP);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};

    logic              w_deb_a;
    logic              w_deb_b;
    logic              w_deb_btn;
    logic [1:0]        w_ab;
    logic signed [3:0] w_delta;
    logic signed [3:0] w_acc_next;
    logic              w_btn_rise;

    logic [1:0]         r_prev_ab;
    logic signed [2:0]  r_acc;
    logic               r_step_cw;
    logic               r_step_ccw;
    logic               r_btn_prev;
    channel_e           r_sel;
    logic [LEVEL_W-1:0] r_red;
    logic [LEVEL_W-1:0] r_green;
    logic [LEVEL_W-1:0] r_blue;

    input_debouncer #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb_a (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (encoder_A),
        .o_level (w_deb_a)
    );

    input_debouncer #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb_b (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (encoder_B),
        .o_level (w_deb_b)
    );

    input_debouncer #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_deb_btn (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (encoder_btn),
        .o_level (w_deb_btn)
    );

    // Saturating step in LEVEL_W+1 bits: the top bit is the carry on the way
    // up and the borrow on the way down.
    function automatic logic [LEVEL_W-1:0] apply_step(
        input logic [LEVEL_W-1:0] lvl,
        input logic               up,
        input logic               down
    );
        logic [LEVEL_W:0]   sum;
        logic [LEVEL_W:0]   diff;
        logic [LEVEL_W-1:0] res;
        sum  = {1'b0, lvl} + STEP_EXT;
        diff = {1'b0, lvl} - STEP_EXT;
        res  = lvl;
        if (up) begin
            res = sum[LEVEL_W] ? LEVEL_MAX : sum[LEVEL_W-1:0];
        end else if (down) begin
            res = diff[LEVEL_W] ? '0 : diff[LEVEL_W-1:0];
        end
        return res;
    endfunction

    // Quadrature transition classifier. Double-bit changes and no-change
    // both yield zero so the accumulator holds.
    always_comb begin
        w_ab    = {w_deb_a, w_deb_b};
        w_delta = 4'sd0;
        case ({r_prev_ab, w_ab})
            4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: w_delta = 4'sd1;
            4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: w_delta = -4'sd1;
            default:                                w_delta = 4'sd0;
        endcase
        // A full detent ends at +/-4, one beyond what the 3-bit accumulator
        // holds, so the final transition is judged in 4 bits.
        w_acc_next = {r_acc[2], r_acc} + w_delta;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_ab  <= AB_IDLE;
            r_acc      <= '0;
            r_step_cw  <= 1'b0;
            r_step_ccw <= 1'b0;
        end else begin
            r_step_cw  <= 1'b0;
            r_step_ccw <= 1'b0;
            r_prev_ab  <= w_ab;
            if (w_ab != r_prev_ab) begin
                if (w_ab == AB_IDLE) begin
                    // Back at the detent: emit a step only for a complete
                    // four-transition sweep, and always start afresh.
                    r_acc <= '0;
                    if (w_acc_next == 4'sd4) begin
                        r_step_cw <= 1'b1;
                    end else if (w_acc_next == -4'sd4) begin
                        r_step_ccw <= 1'b1;
                    end
                end else begin
                    r_acc <= w_acc_next[2:0];
                end
            end
        end
    end

    assign w_btn_rise = w_deb_btn & ~r_btn_prev;

    // The level update reads r_sel before this edge's advance, so a step that
    // coincides with a button edge lands on the old channel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_btn_prev <= 1'b0;
            r_sel      <= CH_RED;
            r_red      <= '0;
            r_green    <= '0;
            r_blue     <= '0;
        end else begin
            r_btn_prev <= w_deb_btn;
            if (w_btn_rise) begin
                r_sel <= next_channel(r_sel);
            end
            if (r_sel == CH_RED) begin
                r_red <= apply_step(r_red, r_step_cw, r_step_ccw);
            end
            if (r_sel == CH_GREEN) begin
                r_green <= apply_step(r_green, r_step_cw, r_step_ccw);
            end
            if (r_sel == CH_BLUE) begin
                r_blue <= apply_step(r_blue, r_step_cw, r_step_ccw);
            end
        end
    end

    assign red_level   = r_red;
    assign green_level = r_green;
    assign blue_level  = r_blue;
    assign sel_channel = r_sel;
    assign step_cw     = r_step_cw;
    assign step_ccw    = r_step_ccw;

endmodule

// File: tb/tb_rgb_encoder_frontend.sv
// tb/tb_rgb_encoder_frontend.sv - directed self-checking bench for rgb_encoder_frontend
module tb_rgb_encoder_frontend;

    logic       clk = 1'b0;
    logic       rst;
    logic       encoder_A;
    logic       encoder_B;
    logic       encoder_btn;
    logic [7:0] red_level;
    logic [7:0] green_level;
    logic [7:0] blue_level;
    logic [1:0] sel_channel;
    logic       step_cw;
    logic       step_ccw;

    int n_checks = 0;
    int n_pass   = 0;
    int n_cw     = 0;
    int n_ccw    = 0;
    int n_both   = 0;

    always #5 clk = ~clk;

    rgb_encoder_frontend #(
        .DEBOUNCE_CYCLES (4),
        .STEP            (1),
        .LEVEL_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .encoder_A   (encoder_A),
        .encoder_B   (encoder_B),
        .encoder_btn (encoder_btn),
        .red_level   (red_level),
        .green_level (green_level),
        .blue_level  (blue_level),
        .sel_channel (sel_channel),
        .step_cw     (step_cw),
        .step_ccw    (step_ccw)
    );

    always @(negedge clk) begin
        if (step_cw)             n_cw++;
        if (step_ccw)            n_ccw++;
        if (step_cw && step_ccw) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic a, input logic b);
        encoder_A = a;
        encoder_B = b;
        hold(10);
    endtask

    task automatic cw_detent();
        set_ab(1'b1, 1'b0);
        set_ab(1'b0, 1'b0);
        set_ab(1'b0, 1'b1);
        set_ab(1'b1, 1'b1);
    endtask

    task automatic ccw_detent();
        set_ab(1'b0, 1'b1);
        set_ab(1'b0, 1'b0);
        set_ab(1'b1, 1'b0);
        set_ab(1'b1, 1'b1);
    endtask

    task automatic press();
        encoder_btn = 1'b1;
        hold(10);
        encoder_btn = 1'b0;
        hold(10);
    endtask

    initial begin
        int lat;
        int red_at;
        int red_after;
        int cw0;
        int ccw0;

        // 1: reset with random pins
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            encoder_A   = 1'($urandom);
            encoder_B   = 1'($urandom);
            encoder_btn = 1'($urandom);
            @(negedge clk);
        end
        chk("rst_red",   red_level,   0);
        chk("rst_green", green_level, 0);
        chk("rst_blue",  blue_level,  0);
        chk("rst_sel",   sel_channel, 0);
        chk("rst_cw",    step_cw,     0);
        chk("rst_ccw",   step_ccw,    0);
        encoder_A   = 1'b1;
        encoder_B   = 1'b1;
        encoder_btn = 1'b0;
        rst         = 1'b1;
        hold(10);
        chk("idle_cw_count",  n_cw,  0);
        chk("idle_ccw_count", n_ccw, 0);

        // 2: one CW detent with latency measured from the last raw edge
        set_ab(1'b1, 1'b0);
        set_ab(1'b0, 1'b0);
        set_ab(1'b0, 1'b1);
        encoder_A = 1'b1;
        lat       = 0;
        red_at    = -1;
        red_after = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (lat != 0 && i == lat + 1) red_after = red_level;
            if (step_cw && lat == 0) begin
                lat    = i;
                red_at = red_level;
            end
        end
        chk("cw_latency",     lat,       7);
        chk("red_at_pulse",   red_at,    0);
        chk("red_after",      red_after, 1);
        chk("one_cw_count",   n_cw,      1);
        chk("one_cw_ccw",     n_ccw,     0);
        chk("one_cw_green",   green_level, 0);
        chk("one_cw_blue",    blue_level,  0);

        // 3: floor at 0, ceiling at 255
        for (int i = 0; i < 3; i++) ccw_detent();
        chk("ccw_count", n_ccw,     3);
        chk("red_floor", red_level, 0);
        for (int i = 0; i < 300; i++) cw_detent();
        chk("red_ceil",  red_level, 255);
        cw_detent();
        chk("red_hold_ceil", red_level, 255);
        chk("cw_count_302",  n_cw,      302);

        // 4: channel select
        press();
        chk("sel_green", sel_channel, 1);
        for (int i = 0; i < 5; i++) cw_detent();
        chk("green_5",   green_level, 5);
        chk("red_kept",  red_level,   255);
        chk("blue_kept", blue_level,  0);
        press();
        chk("sel_blue", sel_channel, 2);
        press();
        chk("sel_wrap", sel_channel, 0);

        // 5: glitches
        cw0  = n_cw;
        ccw0 = n_ccw;
        encoder_A = 1'b0;
        hold(2);
        encoder_A = 1'b1;
        hold(10);
        set_ab(1'b0, 1'b0);
        set_ab(1'b1, 1'b1);
        chk("glitch_cw",    n_cw,        cw0);
        chk("glitch_ccw",   n_ccw,       ccw0);
        chk("glitch_red",   red_level,   255);
        chk("glitch_green", green_level, 5);
        encoder_btn = 1'b1;
        hold(3);
        encoder_btn = 1'b0;
        hold(10);
        chk("bounce_sel", sel_channel, 0);

        // 6: reset mid-detent discards the partial sweep
        set_ab(1'b1, 1'b0);
        set_ab(1'b0, 1'b0);
        rst = 1'b0;
        hold(3);
        rst = 1'b1;
        hold(10);
        cw0  = n_cw;
        ccw0 = n_ccw;
        set_ab(1'b0, 1'b1);
        set_ab(1'b1, 1'b1);
        chk("mid_rst_cw",    n_cw,        cw0);
        chk("mid_rst_ccw",   n_ccw,       ccw0);
        chk("mid_rst_red",   red_level,   0);
        chk("mid_rst_green", green_level, 0);
        chk("mid_rst_sel",   sel_channel, 0);

        // step pulse and button edge arrive at the level logic together
        set_ab(1'b1, 1'b0);
        set_ab(1'b0, 1'b0);
        set_ab(1'b0, 1'b1);
        encoder_A = 1'b1;
        @(negedge clk);
        encoder_btn = 1'b1;
        hold(15);
        chk("simul_red",   red_level,   1);
        chk("simul_green", green_level, 0);
        chk("simul_sel",   sel_channel, 1);
        encoder_btn = 1'b0;
        hold(10);
        chk("never_both", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
